// File: rtl/pipeline_foreground_config.sv
// Frame-synchronous shadow/commit controller for the foreground scale stage.
// Optional per-frame offset animation is enabled by defining FG_CFG_ANIM_EN.
module pipeline_foreground_config #(
  parameter int RESOLUTION_X = 640,
  parameter int RESOLUTION_Y = 480,
  parameter int ANIM_STEP    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [9:0] cmd_data,
  input  logic       frame_start,
  output logic [1:0] ctrl_foreground_scale,
  output logic [9:0] fg_offset_x,
  output logic [9:0] fg_offset_y,
  output logic       pending,
  output logic       commit_done,
  output logic [1:0] dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so the shadows are frozen once a commit is armed.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
`ifdef FG_CFG_ANIM_EN
    S_APPLY = 2'd2,
    S_ANIMATE = 2'd3
`else
    S_APPLY = 2'd2
`endif
  } state_t;

  localparam logic [10:0] HALF_X    = 11'(RESOLUTION_X / 2);
  localparam logic [10:0] HALF_Y    = 11'(RESOLUTION_Y / 2);
  localparam logic [10:0] QUARTER_X = 11'((3 * RESOLUTION_X) / 4);
  localparam logic [10:0] QUARTER_Y = 11'((3 * RESOLUTION_Y) / 4);

  state_t state, state_nxt;

  logic [1:0]  sh_scale;
  logic [9:0]  sh_x, sh_y;
  logic [10:0] max_x, max_y;
  logic [9:0]  tgt_x, tgt_y;
  logic        cmd_fire;

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [10:0] lim);
    return ({1'b0, v} > lim) ? lim[9:0] : v;
  endfunction

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign dbg_state = state;

  // Window limits follow the scale that is about to become live.
  always_comb begin
    max_x = 11'd0;
    max_y = 11'd0;
    case (sh_scale)
      2'b10: begin max_x = HALF_X;    max_y = HALF_Y;    end
      2'b01: begin max_x = QUARTER_X; max_y = QUARTER_Y; end
      default: ;
    endcase
  end

  assign tgt_x = clamp(sh_x, max_x);
  assign tgt_y = clamp(sh_y, max_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_scale <= 2'b00;
      sh_x     <= 10'd0;
      sh_y     <= 10'd0;
    end else if (cmd_fire) begin
      case (cmd_addr)
        2'd0: sh_scale <= cmd_data[1:0];
        2'd1: sh_x     <= cmd_data;
        2'd2: sh_y     <= cmd_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

`ifdef FG_CFG_ANIM_EN
  localparam logic [9:0] STEP = 10'(ANIM_STEP);

  logic at_tgt;

  function automatic logic [9:0] step_to(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] dist;
    dist = (cur < tgt) ? (tgt - cur) : (cur - tgt);
    if (dist > STEP) dist = STEP;
    return (cur < tgt) ? (cur + dist) : (cur - dist);
  endfunction

  assign at_tgt = (fg_offset_x == tgt_x) && (fg_offset_y == tgt_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_foreground_scale <= 2'b00;
      fg_offset_x           <= 10'd0;
      fg_offset_y           <= 10'd0;
    end else if (state == S_ARMED && frame_start) begin
      ctrl_foreground_scale <= sh_scale;
    end else if (state == S_ANIMATE && frame_start && !at_tgt) begin
      fg_offset_x <= step_to(fg_offset_x, tgt_x);
      fg_offset_y <= step_to(fg_offset_y, tgt_y);
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    pending     = 1'b0;
    commit_done = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire && cmd_addr == 2'd3) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        pending = 1'b1;
        if (frame_start) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        pending   = 1'b1;
        state_nxt = S_ANIMATE;
      end
      S_ANIMATE: begin
        if (at_tgt) begin
          commit_done = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          pending = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
`else
  // Live registers load on the frame_start that leaves ARMED, so they are
  // already visible during the one APPLY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_foreground_scale <= 2'b00;
      fg_offset_x           <= 10'd0;
      fg_offset_y           <= 10'd0;
    end else if (state == S_ARMED && frame_start) begin
      ctrl_foreground_scale <= sh_scale;
      fg_offset_x           <= tgt_x;
      fg_offset_y           <= tgt_y;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    pending     = 1'b0;
    commit_done = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire && cmd_addr == 2'd3) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        pending = 1'b1;
        if (frame_start) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        commit_done = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
`endif

endmodule

// File: tb/tb_pipeline_foreground_config.sv
// Randomized self-checking bench for pipeline_foreground_config against a
// frame-level reference model (shadow values, clamp limits, per-frame steps).
module tb_pipeline_foreground_config;

  localparam int RES_X = 640;
  localparam int RES_Y = 480;
  localparam int STEP  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_addr = 2'd0;
  logic [9:0] cmd_data = 10'd0;
  logic       frame_start = 1'b0;
  logic [1:0] ctrl_foreground_scale;
  logic [9:0] fg_offset_x, fg_offset_y;
  logic       pending, commit_done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: what was written, and what the screen currently shows.
  int m_sh_scale, m_sh_x, m_sh_y;
  int m_scale, m_x, m_y;

  pipeline_foreground_config #(
    .RESOLUTION_X(RES_X), .RESOLUTION_Y(RES_Y), .ANIM_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .frame_start(frame_start),
    .ctrl_foreground_scale(ctrl_foreground_scale),
    .fg_offset_x(fg_offset_x), .fg_offset_y(fg_offset_y),
    .pending(pending), .commit_done(commit_done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int ref_clamp(input int scale, input int v, input int res);
    int lim;
    lim = (scale == 2) ? res / 2 : (scale == 1) ? (3 * res) / 4 : 0;
    return (v > lim) ? lim : v;
  endfunction

  function automatic int ref_step(input int cur, input int tgt);
    if (tgt - cur > STEP) return cur + STEP;
    if (cur - tgt > STEP) return cur - STEP;
    return tgt;
  endfunction

  task automatic model_reset();
    m_sh_scale = 0; m_sh_x = 0; m_sh_y = 0;
    m_scale = 0; m_x = 0; m_y = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [9:0] d);
    int n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    case (a)
      2'd0: m_sh_scale = int'(d[1:0]);
      2'd1: m_sh_x = int'(d);
      2'd2: m_sh_y = int'(d);
      default: ;
    endcase
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Issues the frame_start that applies an armed commit and follows it to completion.
  task automatic apply_and_check(input string name);
    int tx, ty, guard;
    bit eq;
    tx = ref_clamp(m_sh_scale, m_sh_x, RES_X);
    ty = ref_clamp(m_sh_scale, m_sh_y, RES_Y);
    pulse_frame();
    m_scale = m_sh_scale;
    checks++;
    if (ctrl_foreground_scale !== 2'(m_scale)) begin
      errors++;
      $display("FAIL %s_scale: got %0d required %0d", name, ctrl_foreground_scale, m_scale);
    end
`ifdef FG_CFG_ANIM_EN
    checks++;
    if (commit_done !== 1'b0 || pending !== 1'b1) begin
      errors++;
      $display("FAIL %s_apply_flags: done=%b pending=%b required 0/1", name, commit_done, pending);
    end
    tick();
    guard = 0;
    forever begin
      eq = (m_x == tx) && (m_y == ty);
      checks++;
      if (fg_offset_x !== 10'(m_x) || fg_offset_y !== 10'(m_y)) begin
        errors++;
        $display("FAIL %s_anim_offs: got %0d,%0d required %0d,%0d", name,
                 fg_offset_x, fg_offset_y, m_x, m_y);
      end
      checks++;
      if (commit_done !== eq || pending !== !eq) begin
        errors++;
        $display("FAIL %s_anim_flags: done=%b pending=%b required %b/%b", name,
                 commit_done, pending, eq, !eq);
      end
      if (eq || guard > 300) break;
      pulse_frame();
      m_x = ref_step(m_x, tx);
      m_y = ref_step(m_y, ty);
      guard++;
    end
`else
    m_x = tx; m_y = ty;
    checks++;
    if (fg_offset_x !== 10'(m_x) || fg_offset_y !== 10'(m_y)) begin
      errors++;
      $display("FAIL %s_offs: got %0d,%0d required %0d,%0d", name,
               fg_offset_x, fg_offset_y, m_x, m_y);
    end
    checks++;
    if (commit_done !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL %s_apply_flags: done=%b pending=%b required 1/0", name, commit_done, pending);
    end
`endif
    tick();
    checks++;
    if (commit_done !== 1'b0 || cmd_ready !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: done=%b ready=%b pending=%b required 0/1/0", name,
               commit_done, cmd_ready, pending);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ctrl_foreground_scale !== 2'b00 || fg_offset_x !== 10'd0 || fg_offset_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d,%0d,%0d required 0,0,0",
               ctrl_foreground_scale, fg_offset_x, fg_offset_y);
    end
    checks++;
    if (cmd_ready !== 1'b1 || pending !== 1'b0 || commit_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b pending=%b done=%b required 1/0/0",
               cmd_ready, pending, commit_done);
    end
  endtask

  task automatic test_basic_commit();
    wr(2'd0, 10'd2); wr(2'd1, 10'd100); wr(2'd2, 10'd50); wr(2'd3, 10'd0);
    // Attempted shadow write while armed must stall and change nothing.
    cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_data = 10'd7;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pending !== 1'b1 || cmd_ready !== 1'b0 || ctrl_foreground_scale !== 2'(m_scale) ||
          fg_offset_x !== 10'(m_x) || fg_offset_y !== 10'(m_y)) begin
        errors++;
        $display("FAIL armed_hold: pending=%b ready=%b scale=%0d x=%0d y=%0d required 1/0/%0d/%0d/%0d",
                 pending, cmd_ready, ctrl_foreground_scale, fg_offset_x, fg_offset_y,
                 m_scale, m_x, m_y);
      end
      tick();
    end
    cmd_valid = 1'b0;
    apply_and_check("basic");
    checks++;
    if (ctrl_foreground_scale !== 2'b10 || fg_offset_x !== 10'd100 || fg_offset_y !== 10'd50) begin
      errors++;
      $display("FAIL basic_final: got %0d,%0d,%0d required 2,100,50",
               ctrl_foreground_scale, fg_offset_x, fg_offset_y);
    end
  endtask

  task automatic test_clamp();
    wr(2'd0, 10'd1); wr(2'd1, 10'd600); wr(2'd2, 10'd400); wr(2'd3, 10'd0);
    apply_and_check("clamp_quarter");
    checks++;
    if (fg_offset_x !== 10'd480 || fg_offset_y !== 10'd360) begin
      errors++;
      $display("FAIL clamp_quarter_val: got %0d,%0d required 480,360", fg_offset_x, fg_offset_y);
    end
    wr(2'd0, 10'd3); wr(2'd1, 10'd5); wr(2'd3, 10'd0);
    apply_and_check("clamp_full");
    checks++;
    if (fg_offset_x !== 10'd0 || fg_offset_y !== 10'd0) begin
      errors++;
      $display("FAIL clamp_full_val: got %0d,%0d required 0,0", fg_offset_x, fg_offset_y);
    end
  endtask

  task automatic test_coincident();
    wr(2'd0, 10'd2); wr(2'd1, 10'd33); wr(2'd2, 10'd17);
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_data = 10'd0; frame_start = 1'b1;
    tick();
    cmd_valid = 1'b0; frame_start = 1'b0;
    repeat (2) begin
      checks++;
      if (pending !== 1'b1 || commit_done !== 1'b0 || ctrl_foreground_scale !== 2'(m_scale) ||
          fg_offset_x !== 10'(m_x) || fg_offset_y !== 10'(m_y)) begin
        errors++;
        $display("FAIL coincident_hold: pending=%b done=%b x=%0d y=%0d required 1/0/%0d/%0d",
                 pending, commit_done, fg_offset_x, fg_offset_y, m_x, m_y);
      end
      tick();
    end
    apply_and_check("coincident");
  endtask

  task automatic test_idle_frame();
    wr(2'd1, 10'd77);
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      checks++;
      if (commit_done !== 1'b0 || pending !== 1'b0 || fg_offset_x !== 10'(m_x) ||
          ctrl_foreground_scale !== 2'(m_scale)) begin
        errors++;
        $display("FAIL idle_frame: done=%b pending=%b x=%0d required 0/0/%0d",
                 commit_done, pending, fg_offset_x, m_x);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr(2'd0, 10'd2); wr(2'd1, 10'd300); wr(2'd3, 10'd0);
    cmd_valid = 1'b1; cmd_addr = 2'd3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_blocked: ready=%b required 0", cmd_ready);
      end
      tick();
    end
    cmd_valid = 1'b0;
    apply_and_check("b2b_first");
    wr(2'd3, 10'd0);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_armed: pending=%b required 1", pending);
    end
    apply_and_check("b2b_second");
  endtask

  task automatic test_reset_armed();
    wr(2'd0, 10'd2); wr(2'd1, 10'd200); wr(2'd2, 10'd100); wr(2'd3, 10'd0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (ctrl_foreground_scale !== 2'b00 || fg_offset_x !== 10'd0 || fg_offset_y !== 10'd0 ||
        pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: scale=%0d x=%0d y=%0d pending=%b required 0,0,0,0",
               ctrl_foreground_scale, fg_offset_x, fg_offset_y, pending);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    pulse_frame();
    tick();
    checks++;
    if (ctrl_foreground_scale !== 2'b00 || fg_offset_x !== 10'd0 || fg_offset_y !== 10'd0 ||
        commit_done !== 1'b0 || pending !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: scale=%0d x=%0d y=%0d done=%b pending=%b ready=%b required 0,0,0,0,0,1",
               ctrl_foreground_scale, fg_offset_x, fg_offset_y, commit_done, pending, cmd_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      wr(2'd0, 10'($urandom_range(0, 3)));
      wr(2'd1, 10'($urandom_range(0, 1023)));
      wr(2'd2, 10'($urandom_range(0, 1023)));
      if ($urandom_range(0, 3) == 0) pulse_frame();
      wr(2'd3, 10'($urandom_range(0, 1023)));
      repeat ($urandom_range(0, 4)) tick();
      apply_and_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_clamp();
    test_coincident();
    test_idle_frame();
    test_back_to_back();
    test_reset_armed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
